ysyx_23060072_ex_stage: RTL and testbench

//  Execute stage of the rv32e pipeline. Accepts one decoded instruction per cycle from the ID/EX

---
 rtl/ysyx_23060072_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ysyx_23060072_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_ex_stage.sv
// ysyx_23060072_ex_stage: rv32e execute stage. A combinational ALU feeds a
// two-entry (main + skid) FIFO toward the LSU. Taken control flow raises a
// registered one-cycle redirect, and the instruction offered in that cycle
// is squashed.

// Combinational ALU: result, branch/jump decision and jump target.
module ysyx_23060072_alu #(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              jump_flag,
    output logic [DATA_W-1:0] jump_pc,
    output logic              is_branch
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_AUIPC  = 5'd11;
    localparam logic [4:0] ALU_JAL    = 5'd12;
    localparam logic [4:0] ALU_JALR   = 5'd13;
    localparam logic [4:0] ALU_BEQ    = 5'd14;
    localparam logic [4:0] ALU_BNE    = 5'd15;
    localparam logic [4:0] ALU_BLT    = 5'd16;
    localparam logic [4:0] ALU_BGE    = 5'd17;
    localparam logic [4:0] ALU_BLTU   = 5'd18;
    localparam logic [4:0] ALU_BGEU   = 5'd19;
    localparam logic [4:0] ALU_FENCEI = 5'd20;
    localparam logic [4:0] ALU_ADDI   = 5'd21;

    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [SH_W-1:0]          sh;
    logic [DATA_W-1:0]        pc_seq;
    logic [DATA_W-1:0]        pc_off;
    logic [DATA_W-1:0]        a_off;

    assign sa     = a;
    assign sb     = b;
    assign sh     = b[SH_W-1:0];
    assign pc_seq = pc + DATA_W'(4);
    assign pc_off = pc + imm;
    assign a_off  = a + imm;

    // Opcode decode; branches produce no result and only a taken/not-taken flag.
    always_comb begin
        result    = '0;
        jump_flag = 1'b0;
        jump_pc   = pc_off;
        is_branch = 1'b0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << sh;
            ALU_SLT:    result = {{(DATA_W-1){1'b0}}, sa < sb};
            ALU_SLTU:   result = {{(DATA_W-1){1'b0}}, a < b};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> sh;
            ALU_SRA:    result = sa >>> sh;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_LUI:    result = imm;
            ALU_AUIPC:  result = pc_off;
            ALU_ADDI:   result = a_off;
            ALU_JAL: begin
                result    = pc_seq;
                jump_flag = 1'b1;
            end
            ALU_JALR: begin
                result    = pc_seq;
                jump_flag = 1'b1;
                jump_pc   = a_off & ~{{(DATA_W-1){1'b0}}, 1'b1};
            end
            ALU_BEQ: begin
                is_branch = 1'b1;
                jump_flag = (a == b);
            end
            ALU_BNE: begin
                is_branch = 1'b1;
                jump_flag = (a != b);
            end
            ALU_BLT: begin
                is_branch = 1'b1;
                jump_flag = (sa < sb);
            end
            ALU_BGE: begin
                is_branch = 1'b1;
                jump_flag = (sa >= sb);
            end
            ALU_BLTU: begin
                is_branch = 1'b1;
                jump_flag = (a < b);
            end
            ALU_BGEU: begin
                is_branch = 1'b1;
                jump_flag = (a >= b);
            end
            ALU_FENCEI: begin
                jump_flag = 1'b1;
                jump_pc   = pc_seq;
            end
            default:    result = '0;
        endcase
    end
endmodule

module ysyx_23060072_ex_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_pc_i,
    input  logic [4:0]        in_alu_op_i,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    input  logic [DATA_W-1:0] in_imm_i,
    input  logic [RD_W-1:0]   in_rd_i,
    input  logic              in_rd_wen_i,
    input  logic [3:0]        in_mem_op_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_pc_o,
    output logic [DATA_W-1:0] out_result_o,
    output logic [DATA_W-1:0] out_store_o,
    output logic [RD_W-1:0]   out_rd_o,
    output logic              out_rd_wen_o,
    output logic [3:0]        out_mem_op_o,
    output logic              redirect_o,
    output logic [DATA_W-1:0] redirect_pc_o
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store;
        logic [RD_W-1:0]   rd;
        logic              rd_wen;
        logic [3:0]        mem_op;
    } entry_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] alu_result;
    logic              jump_flag;
    logic [DATA_W-1:0] jump_pc;
    logic              is_branch;
    logic              acc;
    logic              take;
    logic              drain;
    logic              load_main;
    logic              load_skid;
    logic              shift_skid;
    entry_t            entry_p0;
    entry_t            main_p1;
    entry_t            skid_p1;

    ysyx_23060072_alu #(.DATA_W(DATA_W)) u_alu (
        .op        (in_alu_op_i),
        .pc        (in_pc_i),
        .a         (in_a_i),
        .b         (in_b_i),
        .imm       (in_imm_i),
        .result    (alu_result),
        .jump_flag (jump_flag),
        .jump_pc   (jump_pc),
        .is_branch (is_branch)
    );

    // Ready depends only on buffer occupancy and flush, never on out_ready_i.
    assign in_ready_o = (state != FULL2) & ~flush_i;
    assign acc        = in_valid_i & in_ready_o;
    // The cycle redirect_o is high is the wrong-path squash cycle.
    assign take       = acc & ~redirect_o;
    assign out_valid_o = (state != EMPTY);
    assign drain      = out_valid_o & out_ready_i;

    // Branches retire through the buffer but never write a register.
    assign entry_p0 = '{pc:     in_pc_i,
                        result: alu_result,
                        store:  in_b_i,
                        rd:     in_rd_i,
                        rd_wen: in_rd_wen_i & ~is_branch,
                        mem_op: in_mem_op_i};

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    // Next occupancy and buffer write controls; flush empties the buffer.
    always_comb begin
        next_state = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        if (flush_i) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (take) begin
                        next_state = FULL1;
                        load_main  = 1'b1;
                    end
                end
                FULL1: begin
                    if (take && !drain) begin
                        next_state = FULL2;
                        load_skid  = 1'b1;
                    end else if (!take && drain) begin
                        next_state = EMPTY;
                    end else if (take && drain) begin
                        load_main  = 1'b1;
                    end
                end
                FULL2: begin
                    if (drain) begin
                        next_state = FULL1;
                        shift_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // ---- stage p1: main entry (visible on out_*) ----
    // Main entry loads a fresh result or inherits the skid entry, holding otherwise.
    always_ff @(posedge clk) begin
        if (rst)             main_p1 <= '0;
        else if (load_main)  main_p1 <= entry_p0;
        else if (shift_skid) main_p1 <= skid_p1;
    end

    // Skid entry captures a result that arrives while main is stalled.
    always_ff @(posedge clk) begin
        if (load_skid) skid_p1 <= entry_p0;
    end

    // One-cycle redirect pulse for taken control flow; flush cancels it.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else if (flush_i) begin
            redirect_o    <= 1'b0;
        end else begin
            redirect_o <= take & jump_flag;
            if (take && jump_flag) redirect_pc_o <= jump_pc;
        end
    end

    assign out_pc_o     = main_p1.pc;
    assign out_result_o = main_p1.result;
    assign out_store_o  = main_p1.store;
    assign out_rd_o     = main_p1.rd;
    assign out_rd_wen_o = main_p1.rd_wen;
    assign out_mem_op_o = main_p1.mem_op;
endmodule

// File: tb/tb_ysyx_23060072_ex_stage.sv
// Testbench for ysyx_23060072_ex_stage: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_ysyx_23060072_ex_stage;
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_LUI = 5'd10, OP_AUIPC = 5'd11;
    localparam logic [4:0] OP_JAL = 5'd12, OP_JALR = 5'd13, OP_BEQ = 5'd14, OP_BNE = 5'd15;
    localparam logic [4:0] OP_BLT = 5'd16, OP_BGE = 5'd17, OP_BLTU = 5'd18, OP_BGEU = 5'd19;
    localparam logic [4:0] OP_FENCEI = 5'd20, OP_ADDI = 5'd21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_pc_i = '0;
    logic [4:0]  in_alu_op_i = '0;
    logic [31:0] in_a_i = '0;
    logic [31:0] in_b_i = '0;
    logic [31:0] in_imm_i = '0;
    logic [3:0]  in_rd_i = '0;
    logic        in_rd_wen_i = 1'b0;
    logic [3:0]  in_mem_op_i = '0;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [31:0] out_result_o;
    logic [31:0] out_store_o;
    logic [3:0]  out_rd_o;
    logic        out_rd_wen_o;
    logic [3:0]  out_mem_op_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    always #5 clk = ~clk;

    ysyx_23060072_ex_stage #(.DATA_W(32), .RD_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_alu_op_i(in_alu_op_i),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_imm_i(in_imm_i),
        .in_rd_i(in_rd_i), .in_rd_wen_i(in_rd_wen_i), .in_mem_op_i(in_mem_op_i),
        .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_result_o(out_result_o), .out_store_o(out_store_o),
        .out_rd_o(out_rd_o), .out_rd_wen_o(out_rd_wen_o), .out_mem_op_o(out_mem_op_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] store;
        logic [3:0]  rd;
        logic        wen;
        logic [3:0]  mem;
        logic        jmp;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        m_redir = 1'b0;
    logic [31:0] m_redir_pc = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Architectural meaning of one instruction.
    function automatic ent_t ref_exec(input logic [4:0] op, input logic [31:0] pc, a, b, imm,
                                      input logic [3:0] rd, input logic wen, input logic [3:0] mem);
        ent_t e;
        int   sh;
        e.pc = pc; e.store = b; e.rd = rd; e.wen = wen; e.mem = mem;
        e.result = 32'd0; e.jmp = 1'b0; e.tgt = pc + imm;
        sh = int'(b % 32);
        case (op)
            OP_ADD:    e.result = a + b;
            OP_SUB:    e.result = a - b;
            OP_SLL:    e.result = a << sh;
            OP_SLT:    e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:   e.result = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    e.result = a ^ b;
            OP_SRL:    e.result = a >> sh;
            OP_SRA:    e.result = $unsigned($signed(a) >>> sh);
            OP_OR:     e.result = a | b;
            OP_AND:    e.result = a & b;
            OP_LUI:    e.result = imm;
            OP_AUIPC:  e.result = pc + imm;
            OP_ADDI:   e.result = a + imm;
            OP_JAL:    begin e.result = pc + 32'd4; e.jmp = 1'b1; end
            OP_JALR:   begin e.result = pc + 32'd4; e.jmp = 1'b1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:    begin e.wen = 1'b0; e.jmp = (a == b); end
            OP_BNE:    begin e.wen = 1'b0; e.jmp = (a != b); end
            OP_BLT:    begin e.wen = 1'b0; e.jmp = ($signed(a) < $signed(b)); end
            OP_BGE:    begin e.wen = 1'b0; e.jmp = ($signed(a) >= $signed(b)); end
            OP_BLTU:   begin e.wen = 1'b0; e.jmp = (a < b); end
            OP_BGEU:   begin e.wen = 1'b0; e.jmp = (a >= b); end
            OP_FENCEI: begin e.jmp = 1'b1; e.tgt = pc + 32'd4; end
            default:   e.result = 32'd0;
        endcase
        return e;
    endfunction

    // Reference model advanced at each rising edge from the inputs applied.
    task automatic model_step();
        bit   acc;
        ent_t e;
        if (rst) begin
            q.delete(); m_redir = 1'b0; m_redir_pc = 32'd0;
        end else if (flush_i) begin
            q.delete(); m_redir = 1'b0;
        end else begin
            acc = in_valid_i && (q.size() < 2);
            if (q.size() > 0 && out_ready_i) void'(q.pop_front());
            if (acc && !m_redir) begin
                e = ref_exec(in_alu_op_i, in_pc_i, in_a_i, in_b_i, in_imm_i,
                             in_rd_i, in_rd_wen_i, in_mem_op_i);
                q.push_back(e);
                m_redir = e.jmp;
                if (e.jmp) m_redir_pc = e.tgt;
            end else begin
                m_redir = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] pc, a, b, imm,
                         input logic [3:0] rd, input logic wen, input logic [3:0] mem);
        in_valid_i = 1'b1; in_alu_op_i = op; in_pc_i = pc; in_a_i = a; in_b_i = b;
        in_imm_i = imm; in_rd_i = rd; in_rd_wen_i = wen; in_mem_op_i = mem;
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); flush_i = 1'b0; out_ready_i = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        n_checks++; if (redirect_o !== 1'b0) begin n_errors++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
        n_checks++; if (redirect_pc_o !== 32'd0) begin n_errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc_o); end
        n_checks++; if (out_result_o !== 32'd0 || out_pc_o !== 32'd0) begin n_errors++; $display("FAIL reset_out: got result %h pc %h want 0", out_result_o, out_pc_o); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    endtask

    task automatic test_add();
        out_ready_i = 1'b1;
        drive(OP_ADD, 32'h10, 32'd5, 32'd7, 32'd0, 4'd3, 1'b1, 4'd0);
        tick();
        n_checks++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd12 || out_rd_o !== 4'd3) begin n_errors++;
            $display("FAIL add_first: got v=%b res=%h rd=%0d want v=1 res=0000000c rd=3", out_valid_o, out_result_o, out_rd_o); end
        drive(OP_ADD, 32'h14, 32'd1, 32'd2, 32'd0, 4'd4, 1'b1, 4'd0);
        tick();
        n_checks++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd3 || out_rd_o !== 4'd4) begin n_errors++;
            $display("FAIL add_second: got v=%b res=%h rd=%0d want v=1 res=00000003 rd=4", out_valid_o, out_result_o, out_rd_o); end
        idle(); tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL add_drain: got %b want 0", out_valid_o); end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        drive(OP_ADD, 32'h20, 32'd1, 32'd1, 32'd0, 4'd1, 1'b1, 4'd0); tick();
        drive(OP_ADD, 32'h24, 32'd2, 32'd2, 32'd0, 4'd2, 1'b1, 4'd0); tick();
        n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready_o); end
        drive(OP_ADD, 32'h28, 32'd3, 32'd3, 32'd0, 4'd3, 1'b1, 4'd0); tick();
        n_checks++; if (out_result_o !== 32'd2 || out_rd_o !== 4'd1) begin n_errors++; $display("FAIL bp_hold: got res=%h rd=%0d want 00000002 rd=1", out_result_o, out_rd_o); end
        out_ready_i = 1'b1; tick();
        n_checks++; if (out_result_o !== 32'd4 || in_ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_second: got res=%h rdy=%b want 00000004 rdy=1", out_result_o, in_ready_o); end
        tick(); idle();
        n_checks++; if (out_result_o !== 32'd6 || out_rd_o !== 4'd3) begin n_errors++; $display("FAIL bp_third: got res=%h rd=%0d want 00000006 rd=3", out_result_o, out_rd_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL bp_empty: got %b want 0", out_valid_o); end
    endtask

    task automatic test_branch();
        out_ready_i = 1'b1;
        drive(OP_BEQ, 32'h100, 32'd9, 32'd9, 32'h20, 4'd0, 1'b0, 4'd0); tick();
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h120) begin n_errors++; $display("FAIL beq_redirect: got %b pc=%h want 1 pc=00000120", redirect_o, redirect_pc_o); end
        n_checks++; if (out_valid_o !== 1'b1 || out_rd_wen_o !== 1'b0) begin n_errors++; $display("FAIL beq_entry: got v=%b wen=%b want v=1 wen=0", out_valid_o, out_rd_wen_o); end
        drive(OP_ADD, 32'h104, 32'd100, 32'd1, 32'd0, 4'd5, 1'b1, 4'd0); #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL squash_ready: got %b want 1", in_ready_o); end
        tick(); idle();
        n_checks++; if (out_valid_o !== 1'b0 || redirect_o !== 1'b0) begin n_errors++; $display("FAIL squash: got v=%b redir=%b want 0 0", out_valid_o, redirect_o); end
    endtask

    task automatic test_jalr();
        out_ready_i = 1'b1;
        drive(OP_JALR, 32'h80, 32'h1000, 32'd0, 32'd4, 4'd1, 1'b1, 4'd0); tick();
        n_checks++; if (out_result_o !== 32'h84) begin n_errors++; $display("FAIL jalr_link: got %h want 00000084", out_result_o); end
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1004) begin n_errors++; $display("FAIL jalr_target: got %b pc=%h want 1 pc=00001004", redirect_o, redirect_pc_o); end
        idle(); tick();
        n_checks++; if (redirect_o !== 1'b0) begin n_errors++; $display("FAIL jalr_pulse: got %b want 0", redirect_o); end
        drive(OP_BNE, 32'h200, 32'd3, 32'd3, 32'd8, 4'd2, 1'b1, 4'd0); tick(); idle();
        n_checks++; if (redirect_o !== 1'b0 || out_valid_o !== 1'b1 || out_rd_wen_o !== 1'b0) begin n_errors++;
            $display("FAIL bne_nottaken: got redir=%b v=%b wen=%b want 0 1 0", redirect_o, out_valid_o, out_rd_wen_o); end
        tick();
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        drive(OP_ADD, 32'h2F0, 32'd1, 32'd1, 32'd0, 4'd1, 1'b1, 4'd0); tick();
        drive(OP_JAL, 32'h300, 32'd0, 32'd0, 32'h40, 4'd1, 1'b1, 4'd0); tick();
        n_checks++; if (redirect_o !== 1'b1 || in_ready_o !== 1'b0) begin n_errors++; $display("FAIL flush_setup: got redir=%b rdy=%b want 1 0", redirect_o, in_ready_o); end
        drive(OP_ADD, 32'h304, 32'd1, 32'd1, 32'd0, 4'd2, 1'b1, 4'd0);
        flush_i = 1'b1; #1;
        n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", in_ready_o); end
        tick(); flush_i = 1'b0; idle(); #1;
        n_checks++; if (out_valid_o !== 1'b0 || redirect_o !== 1'b0 || in_ready_o !== 1'b1) begin n_errors++;
            $display("FAIL flush_after: got v=%b redir=%b rdy=%b want 0 0 1", out_valid_o, redirect_o, in_ready_o); end
        out_ready_i = 1'b1;
    endtask

    task automatic test_wrap_and_rst();
        out_ready_i = 1'b1;
        drive(OP_JAL, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h10, 4'd1, 1'b1, 4'd0); tick(); idle();
        n_checks++; if (out_result_o !== 32'd0 || out_pc_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL jal_wrap: got res=%h pc=%h want 00000000 fffffffc", out_result_o, out_pc_o); end
        n_checks++; if (redirect_pc_o !== 32'h0000_000C) begin n_errors++; $display("FAIL jal_wrap_target: got %h want 0000000c", redirect_pc_o); end
        tick();
        out_ready_i = 1'b0;
        drive(OP_ADD, 32'h40, 32'd7, 32'd8, 32'd0, 4'd6, 1'b1, 4'd9); tick();
        drive(OP_XOR, 32'h44, 32'hF0, 32'h0F, 32'd0, 4'd7, 1'b1, 4'd0); tick(); idle();
        rst = 1'b1; tick();
        n_checks++; if (out_valid_o !== 1'b0 || out_result_o !== 32'd0 || out_pc_o !== 32'd0 || out_rd_o !== 4'd0 || out_mem_op_o !== 4'd0) begin n_errors++;
            $display("FAIL rst_mid_out: got v=%b res=%h pc=%h rd=%0d mem=%h want all 0", out_valid_o, out_result_o, out_pc_o, out_rd_o, out_mem_op_o); end
        n_checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'd0) begin n_errors++; $display("FAIL rst_mid_redirect: got %b pc=%h want 0 0", redirect_o, redirect_pc_o); end
        rst = 1'b0; out_ready_i = 1'b1;
    endtask

    task automatic test_random();
        logic [104:0] got, want;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready_i = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 7)
                drive(5'($urandom_range(0, 22)), $urandom & 32'hFFFF_FFFC,
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom),
                      ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else
                idle();
            #1;
            n_checks++; if (in_ready_o !== (!flush_i && q.size() < 2)) begin n_errors++;
                $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, in_ready_o, (!flush_i && q.size() < 2)); end
            tick();
            n_checks++; if (out_valid_o !== (q.size() > 0)) begin n_errors++;
                $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_valid_o, (q.size() > 0)); end
            if (q.size() > 0) begin
                got  = {out_pc_o, out_result_o, out_store_o, out_rd_o, out_rd_wen_o, out_mem_op_o};
                want = {q[0].pc, q[0].result, q[0].store, q[0].rd, q[0].wen, q[0].mem};
                n_checks++; if (got !== want) begin n_errors++; $display("FAIL rnd_entry cyc %0d: got %h want %h", cyc, got, want); end
            end
            n_checks++; if (redirect_o !== m_redir) begin n_errors++; $display("FAIL rnd_redirect cyc %0d: got %b want %b", cyc, redirect_o, m_redir); end
            if (m_redir) begin
                n_checks++; if (redirect_pc_o !== m_redir_pc) begin n_errors++; $display("FAIL rnd_redirect_pc cyc %0d: got %h want %h", cyc, redirect_pc_o, m_redir_pc); end
            end
        end
        idle(); flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_branch();
        test_jalr();
        test_flush();
        test_wrap_and_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
